// File: rtl/bus32_pkg.sv
// bus32_pkg: shared widths, counter saturation constant and bus-word type for bus32_tristate.
package bus32_pkg;

    localparam int BUS_W = 32;
    localparam int CNT_W = 16;
    localparam int EN_CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef logic [BUS_W-1:0] bus_word_t;

endpackage

// File: rtl/bus32_popcnt.sv
// bus32_popcnt: counts enabled drivers and flags the none-enabled and two-or-more-enabled cases.
module bus32_popcnt
    import bus32_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] en,
    output logic         none,
    output logic         multi
);

    logic [EN_CNT_W-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + EN_CNT_W'(en[i]);
    end

    assign none  = cnt == '0;
    assign multi = cnt >= EN_CNT_W'(2);

endmodule

// File: rtl/bus32_tristate.sv
// bus32_tristate: wired-OR bus with keeper register; contention flag/counter enabled by BUS32_CONTENTION_CHK_EN.
module bus32_tristate
    import bus32_pkg::*;
#(
    parameter int N = 3,
    parameter int W = BUS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     oe_n,
    input  logic [N*W-1:0]   d,
    output logic [W-1:0]     y,
    output logic [W-1:0]     q,
    output logic             float_o,
    output logic             contend,
    output logic [CNT_W-1:0] contend_cnt
);

    logic [W-1:0] wired_or;
    logic [W-1:0] q_d;
    logic [W-1:0] q_q;
    logic         none;
    logic         multi;

    bus32_popcnt #(.N(N)) u_popcnt (
        .en   (~oe_n),
        .none (none),
        .multi(multi)
    );

    // Disabled slices are masked to 0 so X on an idle driver never reaches the bus.
    always_comb begin
        wired_or = '0;
        for (int k = 0; k < N; k++) wired_or = wired_or | (d[k*W +: W] & {W{~oe_n[k]}});
    end

    assign y       = none ? q_q : wired_or;
    assign float_o = none;
    assign q       = q_q;

    always_comb q_d = y;

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

`ifdef BUS32_CONTENTION_CHK_EN
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb cnt_d = (multi && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign contend     = multi;
    assign contend_cnt = cnt_q;
`else
    assign contend     = multi & 1'b0;
    assign contend_cnt = '0;
`endif

endmodule

// File: tb/tb_bus32_tristate.sv
// tb_bus32_tristate: randomized and directed checks of bus32_tristate against a behavioural bus model.
module tb_bus32_tristate;

    localparam int N = 3;
    localparam int W = 32;
`ifdef BUS32_CONTENTION_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  oe_n;
    logic [N*W-1:0] d;
    logic [W-1:0]  y;
    logic [W-1:0]  q;
    logic          float_o;
    logic          contend;
    logic [15:0]   contend_cnt;

    int vectors = 0;
    int miscompares = 0;

    bus32_tristate #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .oe_n       (oe_n),
        .d          (d),
        .y          (y),
        .q          (q),
        .float_o    (float_o),
        .contend    (contend),
        .contend_cnt(contend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: keeper value and contention cycle count.
    logic [31:0] m_q;
    int unsigned m_cnt = 0;
    bit armed = 1'b0;

    always begin : compare
        logic [31:0] ey, nq;
        int unsigned ncnt;
        int pop;
        @(negedge clk);
        pop = 0;
        ey = '0;
        for (int k = 0; k < N; k++)
            if (oe_n[k] == 1'b0) begin
                pop++;
                ey = ey | d[k*W +: W];
            end
        if (pop == 0) ey = m_q;
        if (armed) begin
            chk("y", y, ey);
            chk("q", q, m_q);
            chk("float_o", 32'(float_o), 32'(pop == 0));
            chk("contend", 32'(contend), 32'(CHK && pop >= 2));
            chk("contend_cnt", 32'(contend_cnt), m_cnt);
        end
        nq = rst ? 32'h0 : ey;
        ncnt = rst ? 0 : (CHK && pop >= 2 && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        @(posedge clk);
        if (rst) armed = 1'b1;
        m_q = nq;
        m_cnt = ncnt;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] rnd_d();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1;
        oe_n = 3'b111;
        d = rnd_d();
        step();
        rst = 1'b0;
        chk("reset_q", q, 32'h0);
        chk("reset_y", y, 32'h0);
        chk("reset_float", 32'(float_o), 32'd1);
        chk("reset_cnt", 32'(contend_cnt), 32'd0);

        oe_n = 3'b110;
        d = {$urandom, $urandom, 32'h0000_0ABC};
        #1;
        chk("single_y", y, 32'h0000_0ABC);
        chk("single_float", 32'(float_o), 32'd0);
        chk("single_contend", 32'(contend), 32'd0);
        step();
        chk("single_q", q, 32'h0000_0ABC);

        oe_n = 3'b111;
        for (int i = 0; i < 5; i++) begin
            d = rnd_d();
            #1;
            chk("keep_y", y, 32'h0000_0ABC);
            chk("keep_q", q, 32'h0000_0ABC);
            chk("keep_float", 32'(float_o), 32'd1);
            step();
        end

        oe_n = 3'b010;
        d = {32'hF000_0000, $urandom, 32'h0000_000F};
        #1;
        chk("contend_y", y, 32'hF000_000F);
        chk("contend_flag", 32'(contend), CHK ? 32'd1 : 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("contend_cnt_inc", 32'(contend_cnt), CHK ? 32'(i) : 32'd0);
        end

        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            oe_n = 3'($urandom);
            d = rnd_d();
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;

        oe_n = 3'b000;
        d = rnd_d();
        repeat (65540) step();
        chk("sat_cnt", 32'(contend_cnt), CHK ? 32'h0000_FFFF : 32'd0);
        repeat (3) step();
        chk("sat_hold", 32'(contend_cnt), CHK ? 32'h0000_FFFF : 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("sat_clear", 32'(contend_cnt), 32'd0);

        oe_n = 3'b110;
        d = {$urandom, $urandom, 32'h0000_0055};
        step();
        chk("pre_rst_q", q, 32'h0000_0055);
        rst = 1'b1;
        oe_n = 3'b011;
        d = {32'h1234_5678, $urandom, $urandom};
        #1;
        chk("rst_comb_y", y, 32'h1234_5678);
        step();
        rst = 1'b0;
        chk("rst_mid_q", q, 32'h0);
        chk("rst_mid_cnt", 32'(contend_cnt), 32'd0);
        step();
        chk("post_rst_q", q, 32'h1234_5678);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
